// File: rtl/catch_pkg.sv
// Shared types, constants and helpers for the catch game playfield engine.
package catch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } game_state_e;

  // Right-shifting Galois feedback mask for taps 16,14,13,11.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned BcdDigitW = 4;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
  endfunction

  function automatic int unsigned lane_idx(input logic [15:0] lfsr, input int unsigned lanes);
    return {16'h0000, lfsr} % lanes;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter with synchronous clear; holds at all-9s.
module bcd_counter
  import catch_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                        game_clk,
  input  logic                        button_rst,
  input  logic                        inc,
  input  logic                        clr,
  output logic [BcdDigitW*DIGITS-1:0] value,
  output logic                        sat
);

  logic [BcdDigitW*DIGITS-1:0] value_q, value_d;
  logic                        all_nines;
  logic                        carry;

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value_q[BcdDigitW*i +: BcdDigitW] != 4'd9) all_nines = 1'b0;
    end
  end

  always_comb begin
    value_d = value_q;
    carry   = inc & ~all_nines;
    if (clr) begin
      value_d = '0;
      carry   = 1'b0;
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (value_q[BcdDigitW*i +: BcdDigitW] == 4'd9) begin
            value_d[BcdDigitW*i +: BcdDigitW] = 4'd0;
          end else begin
            value_d[BcdDigitW*i +: BcdDigitW] = value_q[BcdDigitW*i +: BcdDigitW] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge game_clk or posedge button_rst) begin
    if (button_rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign sat   = all_nines;

endmodule

// File: rtl/catch_game_core.sv
// Catch game playfield engine: basket, falling objects, BCD score, lives and game sequencing.
module catch_game_core
  import catch_pkg::*;
#(
  parameter int unsigned LANES         = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_DIGITS  = 3,
  parameter int unsigned COUNTDOWN     = 3,
  parameter int unsigned SPAWN_GAP     = 2,
  parameter int unsigned SPEEDUP_EVERY = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          game_clk,
  input  logic                          button_rst,
  input  logic                          tick,
  input  logic                          start,
  input  logic                          btn_left,
  input  logic                          btn_right,
  output logic [$clog2(LANES)-1:0]      basket,
  output logic [LANES*DEPTH-1:0]        field,
  output logic [4*SCORE_DIGITS-1:0]     score_bcd,
  output logic [2:0]                    lives_left,
  output logic [3:0]                    count_val,
  output logic [1:0]                    state,
  output logic                          speed_up,
  output logic                          game_over
);

  localparam int unsigned BasketW = $clog2(LANES);
  localparam int unsigned SpawnW  = $clog2(SPAWN_GAP + 1);
  localparam int unsigned CatchW  = $clog2(SPEEDUP_EVERY + 1);

  localparam logic [BasketW-1:0] BasketHome = BasketW'(LANES / 2);
  localparam logic [BasketW-1:0] BasketMax  = BasketW'(LANES - 1);
  localparam logic [2:0]         LivesInit  = 3'(LIVES);
  localparam logic [3:0]         CountInit  = 4'(COUNTDOWN);
  localparam logic [SpawnW-1:0]  SpawnLast  = SpawnW'(SPAWN_GAP - 1);
  localparam logic [CatchW-1:0]  CatchLast  = CatchW'(SPEEDUP_EVERY - 1);

  game_state_e              state_q, state_d;
  logic [BasketW-1:0]       basket_q, basket_d, basket_mv, spawn_lane;
  logic [LANES*DEPTH-1:0]   field_q, field_d, field_step;
  logic [2:0]               lives_q, lives_d;
  logic [3:0]               count_q, count_d;
  logic                     speed_q, speed_d;
  logic                     over_q, over_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [SpawnW-1:0]        spawn_q, spawn_d, spawn_nxt;
  logic [CatchW-1:0]        catch_q, catch_d;
  logic                     spawn_fire;
  logic                     caught;
  logic [3:0]               misses;
  logic                     score_inc, score_clr, score_sat;

  // Basket position after any move requested this cycle; the catch test uses this value.
  always_comb begin
    basket_mv = basket_q;
    if (btn_left && !btn_right && basket_q != '0) begin
      basket_mv = basket_q - BasketW'(1);
    end else if (btn_right && !btn_left && basket_q != BasketMax) begin
      basket_mv = basket_q + BasketW'(1);
    end
  end

  always_comb begin
    caught = 1'b0;
    misses = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (field_q[l*DEPTH + DEPTH - 1]) begin
        if (BasketW'(l) == basket_mv) caught = 1'b1;
        else                          misses = misses + 4'd1;
      end
    end
  end

  // Shift every lane down one row, dropping the bottom row, then place any new spawn on top.
  always_comb begin
    spawn_fire = (spawn_q == SpawnLast);
    spawn_nxt  = spawn_fire ? '0 : spawn_q + SpawnW'(1);
    spawn_lane = BasketW'(lane_idx(lfsr_q, LANES));
    field_step = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        field_step[l*DEPTH + r] = field_q[l*DEPTH + r - 1];
      end
      if (spawn_fire && BasketW'(l) == spawn_lane) field_step[l*DEPTH] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    basket_d  = basket_q;
    field_d   = field_q;
    lives_d   = lives_q;
    count_d   = count_q;
    spawn_d   = spawn_q;
    catch_d   = catch_q;
    speed_d   = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    lfsr_d    = lfsr_next(lfsr_q);

    // start re-initialises from any state and masks a same-cycle tick.
    if (start) begin
      state_d   = StCount;
      basket_d  = BasketHome;
      field_d   = '0;
      lives_d   = LivesInit;
      count_d   = CountInit;
      spawn_d   = '0;
      catch_d   = '0;
      score_clr = 1'b1;
    end else begin
      unique case (state_q)
        StCount: begin
          if (tick) begin
            if (count_q <= 4'd1) begin
              state_d = StPlay;
              count_d = '0;
            end else begin
              count_d = count_q - 4'd1;
            end
          end
        end
        StPlay: begin
          basket_d = basket_mv;
          if (tick) begin
            score_inc = caught & ~score_sat;
            lives_d   = ({1'b0, lives_q} <= misses) ? 3'd0 : lives_q - misses[2:0];
            if (lives_d == 3'd0) begin
              state_d = StOver;
            end else begin
              field_d = field_step;
              spawn_d = spawn_nxt;
              if (caught) begin
                if (catch_q == CatchLast) begin
                  catch_d = '0;
                  speed_d = 1'b1;
                end else begin
                  catch_d = catch_q + CatchW'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end

    over_d = (state_d == StOver);
  end

  always_ff @(posedge game_clk or posedge button_rst) begin
    if (button_rst) begin
      state_q  <= StIdle;
      basket_q <= BasketHome;
      field_q  <= '0;
      lives_q  <= LivesInit;
      count_q  <= '0;
      speed_q  <= 1'b0;
      over_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      spawn_q  <= '0;
      catch_q  <= '0;
    end else begin
      state_q  <= state_d;
      basket_q <= basket_d;
      field_q  <= field_d;
      lives_q  <= lives_d;
      count_q  <= count_d;
      speed_q  <= speed_d;
      over_q   <= over_d;
      lfsr_q   <= lfsr_d;
      spawn_q  <= spawn_d;
      catch_q  <= catch_d;
    end
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .game_clk   (game_clk),
    .button_rst (button_rst),
    .inc        (score_inc),
    .clr        (score_clr),
    .value      (score_bcd),
    .sat        (score_sat)
  );

  assign basket     = basket_q;
  assign field      = field_q;
  assign lives_left = lives_q;
  assign count_val  = count_q;
  assign state      = state_q;
  assign speed_up   = speed_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_catch_game_core.sv
// Directed bench for catch_game_core; a small spec model predicts LFSR-driven spawn lanes.
module tb_catch_game_core;

  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int LIVES = 3;
  localparam int CD    = 3;
  localparam int GAP   = 2;
  localparam int SPEED = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                   game_clk = 1'b0;
  logic                   button_rst = 1'b1;
  logic                   tick = 1'b0, start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [1:0]             basket;
  logic [LANES*DEPTH-1:0] field;
  logic [11:0]            score_bcd;
  logic [2:0]             lives_left;
  logic [3:0]             count_val;
  logic [1:0]             state;
  logic                   speed_up, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]            m_lfsr;
  logic [LANES*DEPTH-1:0] m_field;
  int m_state, m_basket, m_score, m_lives, m_count, m_spawn, m_catch;

  catch_game_core #(
    .LANES (LANES), .DEPTH (DEPTH), .LIVES (LIVES), .SCORE_DIGITS (3), .COUNTDOWN (CD),
    .SPAWN_GAP (GAP), .SPEEDUP_EVERY (SPEED), .LFSR_SEED (SEED)
  ) dut (
    .game_clk (game_clk), .button_rst (button_rst), .tick (tick), .start (start),
    .btn_left (btn_left), .btn_right (btn_right), .basket (basket), .field (field),
    .score_bcd (score_bcd), .lives_left (lives_left), .count_val (count_val),
    .state (state), .speed_up (speed_up), .game_over (game_over)
  );

  always #5 game_clk = ~game_clk;

  function automatic logic [15:0] galois(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) begin
      n[15] = ~n[15]; n[13] = ~n[13]; n[12] = ~n[12]; n[10] = ~n[10];
    end
    return n;
  endfunction

  always @(posedge game_clk or posedge button_rst) begin
    if (button_rst) m_lfsr <= SEED;
    else            m_lfsr <= galois(m_lfsr);
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bottom_lane();
    for (int ln = 0; ln < LANES; ln++) if (m_field[ln*DEPTH + DEPTH - 1]) return ln;
    return -1;
  endfunction

  function automatic int lowest_lane();
    for (int row = DEPTH - 1; row >= 0; row--)
      for (int ln = 0; ln < LANES; ln++) if (m_field[ln*DEPTH + row]) return ln;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_basket = LANES / 2; m_field = '0; m_score = 0; m_lives = LIVES;
    m_count = 0; m_spawn = 0; m_catch = 0;
  endtask

  task automatic model_start();
    m_state = 1; m_basket = LANES / 2; m_field = '0; m_score = 0; m_lives = LIVES;
    m_count = CD; m_spawn = 0; m_catch = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit l, input bit r);
    int miss;
    bit hit;
    logic [LANES*DEPTH-1:0] nf;
    if (s) begin
      model_start();
      return;
    end
    if (m_state == 1 && t) begin
      if (m_count == 1) begin m_state = 2; m_count = 0; end
      else m_count = m_count - 1;
    end else if (m_state == 2) begin
      if (l && !r && m_basket > 0) m_basket--;
      if (r && !l && m_basket < LANES - 1) m_basket++;
      if (t) begin
        miss = 0; hit = 0;
        for (int ln = 0; ln < LANES; ln++)
          if (m_field[ln*DEPTH + DEPTH - 1]) begin
            if (ln == m_basket) hit = 1; else miss++;
          end
        if (hit && m_score < 999) m_score++;
        m_lives = (miss >= m_lives) ? 0 : m_lives - miss;
        if (m_lives == 0) begin
          m_state = 3;
        end else begin
          nf = '0;
          for (int ln = 0; ln < LANES; ln++)
            for (int row = 1; row < DEPTH; row++) nf[ln*DEPTH + row] = m_field[ln*DEPTH + row - 1];
          m_spawn++;
          if (m_spawn == GAP) begin
            m_spawn = 0;
            nf[(int'(m_lfsr) % LANES) * DEPTH] = 1'b1;
          end
          m_field = nf;
          if (hit) begin
            m_catch++;
            if (m_catch == SPEED) m_catch = 0;
          end
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic cycle(input bit s, input bit t, input bit l, input bit r);
    start = s; tick = t; btn_left = l; btn_right = r;
    model_step(s, t, l, r);
    @(posedge game_clk);
    @(negedge game_clk);
    start = 1'b0; tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic move_to(input int lane);
    for (int k = 0; k < 8 && m_basket != lane; k++) cycle(0, 0, m_basket > lane, m_basket < lane);
  endtask

  task automatic advance_until_bottom(output int lane);
    int k;
    int tgt;
    k = 0;
    lane = bottom_lane();
    while (lane < 0 && k < 40) begin
      tgt = lowest_lane();
      if (tgt >= 0) move_to(tgt);
      cycle(0, 1, 0, 0);
      lane = bottom_lane();
      k++;
    end
    if (lane < 0) begin
      n_tests++; n_fail++;
      $display("FAIL advance_timeout: got no bottom object, want one within 40 ticks");
    end
  endtask

  task automatic catch_one();
    int l;
    advance_until_bottom(l);
    if (l >= 0) begin
      move_to(l);
      cycle(0, 1, 0, 0);
    end
  endtask

  task automatic miss_one();
    int l;
    advance_until_bottom(l);
    if (l >= 0) begin
      move_to((l + 1) % LANES);
      cycle(0, 1, 0, 0);
    end
  endtask

  task automatic play_from_count();
    repeat (CD) cycle(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    button_rst = 1'b1;
    model_reset();
    repeat (2) @(negedge game_clk);
    button_rst = 1'b0;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_tests++; if (basket !== 2'd1) begin n_fail++; $display("FAIL reset_basket: got %0d want 1", basket); end
    n_tests++; if ({field, score_bcd} !== '0) begin
      n_fail++; $display("FAIL reset_field_score: got %h/%h want 0/000", field, score_bcd); end
    n_tests++; if ({lives_left, count_val, speed_up, game_over} !== {3'd3, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_misc: got lives %0d count %0d spd %b over %b want 3 0 0 0",
                         lives_left, count_val, speed_up, game_over); end
  endtask

  task automatic test_countdown();
    cycle(1, 0, 0, 0);
    n_tests++; if (state !== 2'd1 || count_val !== 4'd3) begin
      n_fail++; $display("FAIL count_entry: got st %0d cnt %0d want 1 3", state, count_val); end
    cycle(0, 0, 0, 1);
    n_tests++; if (basket !== 2'd1) begin n_fail++; $display("FAIL count_btn_ignored: got %0d want 1", basket); end
    cycle(0, 1, 0, 0);
    n_tests++; if (count_val !== 4'd2) begin n_fail++; $display("FAIL count_2: got %0d want 2", count_val); end
    cycle(0, 1, 0, 0);
    n_tests++; if (count_val !== 4'd1) begin n_fail++; $display("FAIL count_1: got %0d want 1", count_val); end
    cycle(0, 1, 0, 0);
    n_tests++; if (state !== 2'd2 || count_val !== 4'd0) begin
      n_fail++; $display("FAIL count_to_play: got st %0d cnt %0d want 2 0", state, count_val); end
    n_tests++; if (field !== '0 || lives_left !== 3'd3 || score_bcd !== 12'h000) begin
      n_fail++; $display("FAIL play_entry: got f %h l %0d s %h want 0 3 000", field, lives_left, score_bcd); end
  endtask

  task automatic test_catch();
    int l;
    advance_until_bottom(l);
    if (l >= 0) begin
      move_to(l);
      cycle(0, 1, 0, 0);
      n_tests++; if (score_bcd !== 12'h001 || lives_left !== 3'd3) begin
        n_fail++; $display("FAIL catch_score: got s %h l %0d want 001 3", score_bcd, lives_left); end
      n_tests++; if (field[l*DEPTH + DEPTH - 1] !== 1'b0 || field !== m_field) begin
        n_fail++; $display("FAIL catch_field: got %b want %b", field, m_field); end
    end
  endtask

  task automatic test_move_on_tick();
    int l;
    advance_until_bottom(l);
    if (l >= 0) begin
      if (l > 0) begin move_to(l - 1); cycle(0, 1, 0, 1); end
      else begin move_to(1); cycle(0, 1, 1, 0); end
      n_tests++; if (score_bcd !== 12'h002 || basket !== 2'(l) || lives_left !== 3'd3) begin
        n_fail++; $display("FAIL move_on_tick: got s %h b %0d l %0d want 002 %0d 3",
                           score_bcd, basket, lives_left, l); end
    end
  endtask

  task automatic test_basket();
    move_to(0);
    cycle(0, 0, 1, 0);
    n_tests++; if (basket !== 2'd0) begin n_fail++; $display("FAIL basket_sat_left: got %0d want 0", basket); end
    cycle(0, 0, 1, 1);
    n_tests++; if (basket !== 2'd0) begin n_fail++; $display("FAIL basket_both: got %0d want 0", basket); end
    cycle(0, 0, 0, 1);
    n_tests++; if (basket !== 2'd1) begin n_fail++; $display("FAIL basket_right: got %0d want 1", basket); end
    move_to(LANES - 1);
    cycle(0, 0, 0, 1);
    n_tests++; if (basket !== 2'd2) begin n_fail++; $display("FAIL basket_sat_right: got %0d want 2", basket); end
  endtask

  task automatic test_miss();
    miss_one();
    n_tests++; if (lives_left !== 3'd2 || score_bcd !== 12'h002) begin
      n_fail++; $display("FAIL miss: got l %0d s %h want 2 002", lives_left, score_bcd); end
  endtask

  task automatic test_restart();
    cycle(1, 1, 0, 0);
    n_tests++; if (state !== 2'd1 || count_val !== 4'd3 || score_bcd !== 12'h000 || lives_left !== 3'd3) begin
      n_fail++; $display("FAIL soft_restart: got st %0d c %0d s %h l %0d want 1 3 000 3",
                         state, count_val, score_bcd, lives_left); end
    play_from_count();
  endtask

  task automatic test_speedup_and_sat();
    int k;
    for (int i = 1; i <= 20; i++) begin
      catch_one();
      if (i == 9 || i == 10 || i == 20) begin
        n_tests++; if (speed_up !== (i % 10 == 0)) begin
          n_fail++; $display("FAIL speed_up_catch%0d: got %b want %b", i, speed_up, i % 10 == 0); end
      end
      if (i % 10 == 0) begin
        cycle(0, 0, 0, 0);
        n_tests++; if (speed_up !== 1'b0) begin
          n_fail++; $display("FAIL speed_up_width%0d: got %b want 0", i, speed_up); end
      end
    end
    k = 0;
    while (m_score < 998 && k < 2000) begin catch_one(); k++; end
    n_tests++; if (score_bcd !== 12'h998 || lives_left !== 3'd3) begin
      n_fail++; $display("FAIL score_998: got s %h l %0d want 998 3", score_bcd, lives_left); end
    catch_one();
    n_tests++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL score_999: got %h want 999", score_bcd); end
    catch_one();
    n_tests++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL score_sat: got %h want 999", score_bcd); end
  endtask

  task automatic test_over();
    logic [LANES*DEPTH-1:0] frozen;
    logic [1:0]             b_hold;
    cycle(1, 0, 0, 0);
    play_from_count();
    repeat (3) miss_one();
    n_tests++; if (state !== 2'd3 || game_over !== 1'b1 || lives_left !== 3'd0) begin
      n_fail++; $display("FAIL over_entry: got st %0d go %b l %0d want 3 1 0", state, game_over, lives_left); end
    frozen = m_field;
    b_hold = 2'(m_basket);
    for (int i = 0; i < 5; i++) cycle(0, 1, i[0], ~i[0]);
    n_tests++; if (field !== frozen || basket !== b_hold || game_over !== 1'b1) begin
      n_fail++; $display("FAIL over_frozen: got f %b b %0d go %b want %b %0d 1",
                         field, basket, game_over, frozen, b_hold); end
    cycle(1, 0, 0, 0);
    n_tests++; if (state !== 2'd1 || score_bcd !== 12'h000 || lives_left !== 3'd3 ||
                   count_val !== 4'd3 || game_over !== 1'b0 || field !== '0) begin
      n_fail++; $display("FAIL over_restart: got st %0d s %h l %0d c %0d go %b f %h want 1 000 3 3 0 0",
                         state, score_bcd, lives_left, count_val, game_over, field); end
  endtask

  task automatic test_reset_mid();
    play_from_count();
    catch_one();
    catch_one();
    #2 button_rst = 1'b1;
    #1;
    n_tests++; if ({state, basket, field, score_bcd} !== {2'd0, 2'd1, 12'h000, 12'h000}) begin
      n_fail++; $display("FAIL midreset_core: got st %0d b %0d f %h s %h want 0 1 0 000",
                         state, basket, field, score_bcd); end
    n_tests++; if ({lives_left, count_val, speed_up, game_over} !== {3'd3, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_misc: got l %0d c %0d spd %b go %b want 3 0 0 0",
                         lives_left, count_val, speed_up, game_over); end
    model_reset();
    @(negedge game_clk);
    button_rst = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, want finish before 900000 ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_countdown();
    test_catch();
    test_move_on_tick();
    test_basket();
    test_miss();
    test_restart();
    test_speedup_and_sat();
    test_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
